// File: rtl/fsm_receptor.sv
// Four-phase handshake receiver feeding a first-word-fall-through FIFO.
// One word is captured per request; illegal send codes latch a sticky error.
module fsm_receptor #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               send,
    input  logic [15:0]              dado,
    output logic                     ack,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rx_count,
    output logic                     proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACKD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_rx_count;
    logic            r_proto_err;

    logic            w_full;
    logic            w_empty;
    logic            w_wr;
    logic            w_rd;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_rd    = !w_empty && out_ready;
    // Full is judged on the registered level, so a same-cycle read cannot free a slot.
    assign w_wr    = (r_state == IDLE) && (send == 2'b01) && !w_full;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_wr) w_next = ACKD;
            ACKD: if (send == 2'b00) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_rx_count  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wr) begin
                r_wptr     <= r_wptr + PW'(1);
                r_rx_count <= r_rx_count + 8'd1;
            end
            if (w_rd) r_rptr <= r_rptr + PW'(1);
            if (w_wr && !w_rd)
                r_level <= r_level + LW'(1);
            else if (!w_wr && w_rd)
                r_level <= r_level - LW'(1);
            if (send[1]) r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wptr] <= dado;
    end

    assign ack       = (r_state == ACKD);
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 16'h0000 : r_mem[r_rptr];
    assign level     = r_level;
    assign rx_count  = r_rx_count;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_fsm_receptor.sv
// Bench for fsm_receptor: queue-based reference model, directed and random scenarios.
module tb_fsm_receptor;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int VW    = 27 + LW;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      send;
    logic [15:0]     dado;
    logic            ack;
    logic [15:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic [LW-1:0]   level;
    logic [7:0]      rx_count;
    logic            proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q[$];
    logic        m_ack;
    logic [7:0]  m_cnt;
    logic        m_err;

    fsm_receptor #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .dado      (dado),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .rx_count  (rx_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_vec();
        logic [15:0] head;
        head = (q.size() != 0) ? q[0] : 16'h0000;
        return {m_ack, q.size() != 0, head, LW'(q.size()), m_cnt, m_err};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {ack, out_valid, out_data, level, rx_count, proto_err};
    endfunction

    // One clock: the model applies the rules at the rising edge, then we
    // move to the falling edge where outputs are sampled and inputs changed.
    task automatic cyc();
        bit rd, wr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ack = 1'b0;
            m_cnt = 8'd0;
            m_err = 1'b0;
        end else begin
            rd = (q.size() != 0) && out_ready;
            wr = !m_ack && (send == 2'b01) && (q.size() < DEPTH);
            if (send[1]) m_err = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) begin
                q.push_back(dado);
                m_cnt = m_cnt + 8'd1;
            end
            if (m_ack) begin
                if (send == 2'b00) m_ack = 1'b0;
            end else begin
                m_ack = wr;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send = 2'b00;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        dado = 16'h1234;
        do_reset();
        n_tests++;
        if (dut_vec() !== {1'b0, 1'b0, 16'h0000, LW'(0), 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got %h exp %h", dut_vec(),
                     {1'b0, 1'b0, 16'h0000, LW'(0), 8'd0, 1'b0});
        end
    endtask

    task automatic test_single();
        do_reset();
        send = 2'b01;
        dado = 16'hA5A5;
        cyc();
        n_tests++;
        if ({ack, out_valid, out_data, rx_count} !== {1'b1, 1'b1, 16'hA5A5, 8'd1}) begin
            n_fail++;
            $display("FAIL single_xfer got %h exp %h",
                     {ack, out_valid, out_data, rx_count}, {1'b1, 1'b1, 16'hA5A5, 8'd1});
        end
        send = 2'b00;
        cyc();
        n_tests++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack_drop got %b exp 0", ack);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send = 2'b01;
            dado = 16'(i);
            cyc();
            send = 2'b00;
            cyc();
        end
        send = 2'b01;
        dado = 16'd5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if ({ack, level} !== {1'b0, LW'(4)}) begin
                n_fail++;
                $display("FAIL fill_stall got ack=%b level=%0d exp ack=0 level=4", ack, level);
            end
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_tests++;
        if ({ack, level} !== {1'b0, LW'(3)}) begin
            n_fail++;
            $display("FAIL fill_read_no_write got ack=%b level=%0d exp ack=0 level=3", ack, level);
        end
        cyc();
        n_tests++;
        if ({ack, level} !== {1'b1, LW'(4)}) begin
            n_fail++;
            $display("FAIL fill_accept got ack=%b level=%0d exp ack=1 level=4", ack, level);
        end
        send = 2'b00;
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            n_tests++;
            if ({out_valid, out_data} !== {1'b1, 16'(k)}) begin
                n_fail++;
                $display("FAIL fill_drain got %h exp %h", {out_valid, out_data}, {1'b1, 16'(k)});
            end
            cyc();
        end
        n_tests++;
        if (dut_vec() !== exp_vec() || level !== LW'(0)) begin
            n_fail++;
            $display("FAIL fill_empty got %h exp %h", dut_vec(), exp_vec());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_held();
        do_reset();
        send = 2'b01;
        dado = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            cyc();
            dado = 16'($urandom);
            n_tests++;
            if ({ack, level, rx_count} !== {1'b1, LW'(1), 8'd1}) begin
                n_fail++;
                $display("FAIL held_req got ack=%b level=%0d cnt=%0d exp 1/1/1",
                         ack, level, rx_count);
            end
        end
        send = 2'b00;
        cyc();
        n_tests++;
        if ({ack, out_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL held_release got %h exp %h", {ack, out_data}, {1'b0, 16'hBEEF});
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send = 2'b11;
        dado = 16'h7777;
        cyc();
        send = 2'b00;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({proto_err, level, ack} !== {1'b1, LW'(0), 1'b0}) begin
                n_fail++;
                $display("FAIL illegal_sticky got err=%b level=%0d ack=%b exp 1/0/0",
                         proto_err, level, ack);
            end
            cyc();
        end
        send = 2'b01;
        cyc();
        send = 2'b10;
        cyc();
        n_tests++;
        if ({ack, level} !== {1'b1, LW'(1)}) begin
            n_fail++;
            $display("FAIL illegal_in_ackd got ack=%b level=%0d exp 1/1", ack, level);
        end
        send = 2'b00;
        do_reset();
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_reset got %b exp 0", proto_err);
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            send = 2'b01;
            dado = 16'hC000 + 16'(i);
            cyc();
            send = 2'b00;
            cyc();
        end
        send = 2'b01;
        dado = 16'hC002;
        out_ready = 1'b1;
        cyc();
        send = 2'b00;
        out_ready = 1'b0;
        n_tests++;
        if ({ack, level, out_data} !== {1'b1, LW'(2), 16'hC001}) begin
            n_fail++;
            $display("FAIL concurrent got %h exp %h", {ack, level, out_data},
                     {1'b1, LW'(2), 16'hC001});
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        n_tests++;
        if ({level, out_data} !== {LW'(1), 16'hC002}) begin
            n_fail++;
            $display("FAIL concurrent_order got %h exp %h", {level, out_data},
                     {LW'(1), 16'hC002});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit got;
        do_reset();
        for (int t = 0; t < 256; t++) begin
            send = 2'b01;
            dado = 16'($urandom);
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                out_ready = 1'($urandom);
                cyc();
                n_tests++;
                if (dut_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL wrap_req t=%0d got %h exp %h", t, dut_vec(), exp_vec());
                end
                got = ack;
            end
            if (!got) begin
                n_fail++;
                $display("FAIL wrap_timeout t=%0d ack=%b exp 1", t, ack);
            end
            send = 2'b00;
            cyc();
        end
        n_tests++;
        if (rx_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_count got %0d exp 0", rx_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_drain got %h exp %h", dut_vec(), exp_vec());
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            send = (r < 45) ? 2'b01 : (r < 97) ? 2'b00 : 2'(r);
            dado = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random i=%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send = 2'b01;
        dado = 16'h0F0F;
        cyc();
        rst = 1'b1;
        cyc();
        n_tests++;
        if ({ack, out_valid, level, rx_count} !== {1'b0, 1'b0, LW'(0), 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid got %h exp %h", {ack, out_valid, level, rx_count},
                     {1'b0, 1'b0, LW'(0), 8'd0});
        end
        rst = 1'b0;
        cyc();
        n_tests++;
        if ({ack, out_data, rx_count} !== {1'b1, 16'h0F0F, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_rearm got %h exp %h", {ack, out_data, rx_count},
                     {1'b1, 16'h0F0F, 8'd1});
        end
        send = 2'b00;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        send = 2'b00;
        dado = 16'h0000;
        out_ready = 1'b0;
        q.delete();
        m_ack = 1'b0;
        m_cnt = 8'd0;
        m_err = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_held();
        test_illegal();
        test_concurrent();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_receptor.md
FSM_RECEPTOR -- requirements
Module: fsm_receptor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the receive FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port send, input, 2 bits: request from the processor; 2'b01 means request, 2'b00 means idle, 2'b10 and 2'b11 are illegal.
REQ-005 SHALL have port dado, input, 16 bits: data word, valid whenever send==2'b01.
REQ-006 SHALL have port ack, output, 1 bit: handshake acknowledge, registered.
REQ-007 SHALL have port out_data, output, 16 bits: head-of-FIFO word.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the head word when out_valid && out_ready.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have port rx_count, output, 8 bits: total words accepted, wrapping modulo 256.
REQ-012 SHALL have port proto_err, output, 1 bit: sticky illegal-send flag.

Function
REQ-013 SHALL implement a four-phase handshake FSM with two states, IDLE (ack=0) and ACKD (ack=1), where ack is a direct decode of the registered state.
REQ-014 In IDLE, when send==2'b01 and level<DEPTH, SHALL write dado into the FIFO, increment rx_count, and move to ACKD on the same edge; ack is therefore high in the first cycle after the request is seen.
REQ-015 In IDLE, when send==2'b01 and level==DEPTH, SHALL stay in IDLE with ack=0 and no write, and SHALL accept on the first edge where level<DEPTH, with level sampled from the register.
REQ-016 In ACKD, SHALL stay while send!=2'b00 and return to IDLE on the edge where send==2'b00, and SHALL not write again until the FSM is back in IDLE (one word per request).
REQ-017 When send is 2'b10 or 2'b11 on any edge, SHALL set proto_err=1 until reset; in IDLE such a value SHALL not cause a write; in ACKD it SHALL hold ACKD.
REQ-018 SHALL present the FIFO as first-word-fall-through: out_data=head entry when out_valid=1, otherwise 16'h0000.
REQ-019 SHALL write a word into FIFO storage so that out_valid=1 in the cycle after the write when the FIFO was empty.
REQ-020 On a read (out_valid && out_ready), SHALL advance the read pointer on the edge; a read when empty SHALL be ignored.
REQ-021 On a simultaneous write and read, SHALL leave level unchanged and move both pointers; when full, a read in the same cycle SHALL not enable that cycle's write (REQ-015).
REQ-022 SHALL wrap read and write pointers modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-023 SHALL wrap rx_count from 255 to 0 without any flag.

Reset
REQ-024 On rst=1 at a clock edge, SHALL force state=IDLE, ack=0, FIFO pointers=0, level=0, out_valid=0, out_data=16'h0000, rx_count=0, proto_err=0, and rst SHALL take priority over all other inputs.
REQ-025 Reset asserted mid-handshake (ACKD) SHALL drop ack on the next cycle and discard all buffered words; a send==2'b01 still held after reset SHALL be accepted as a new request.
REQ-026 FIFO storage contents need not be reset.

Verification
REQ-027 Single transfer: send=01, dado=16'hA5A5 -> ack=1 the next cycle, out_valid=1, out_data=16'hA5A5, rx_count=1; send=00 -> ack=0 one cycle later.
REQ-028 Fill: with out_ready=0, complete 4 handshakes of 1,2,3,4 then send=01 with 5 -> level=4, ack stays 0; pulse out_ready for one cycle -> ack=1 the next cycle; draining yields 2,3,4,5 in order.
REQ-029 Held request: send=01 held for 10 cycles -> exactly one write and level=1; ack stays 1 until send=00.
REQ-030 Illegal code: send=11 for one cycle in IDLE -> proto_err=1 persisting, no write, level=0; rst -> proto_err=0.
REQ-031 Concurrent: level=2 with out_ready=1 and a new request accepted -> level remains 2 on that edge and order is preserved.
REQ-032 Wrap: 256 transfers -> rx_count=0, with no data loss across pointer wrap.
